min_max_finder_param: RTL
=========================

// Module: min_max_finder_param
// PURPOSE
//  Finds the max and min of the first Len entries of an internal DEPTH x WIDTH array, plus their indices.
//  Array is written through a simple write port. A scan starts on Start; results are held until Ack.
//  Each CMP cycle compares one element against both Max and Min.
//  Standalone lab datapath/control block; one-hot state is exported for debug.
// PARAMETERS
//  WIDTH   8   element width in bits (>=2)
//  DEPTH   16  number of array entries (>=2)
//  SIGNED  0   0: unsigned compare; 1: two's-complement compare
//  AW      $clog2(DEPTH)  index width (derived, not overridden)
// PORTS
//  Clk      in   1        rising-edge clock
//  Reset_n  in   1        asynchronous, active-low reset
//  Wr_En    in   1        array write strobe; honoured only in INI
//  Wr_Addr  in   AW       array write address
//  Wr_Data  in   WIDTH    array write data
//  Start    in   1        begin scan; sampled only in INI
//  Len      in   AW+1     element count; sampled with Start
//  Ack      in   1        result consumed; sampled only in DONE
//  Max      out  WIDTH    largest element found
//  Min      out  WIDTH    smallest element found
//  Max_Idx  out  AW       index of Max
//  Min_Idx  out  AW       index of Min
//  Done     out  1        high exactly while in DONE
//  Qi,Ql,Qc,Qd out 1 each  one-hot state bits for INI, LOAD, CMP, DONE
// BEHAVIOUR
//  Reset (async): state=INI, Max=Min=0, Max_Idx=Min_Idx=0, I=0, N=0.
//   Array contents are not reset. Reset mid-scan aborts to INI; no partial result is flagged.
//  INI: I<=0. Wr_En writes M[Wr_Addr]<=Wr_Data.
//   If Start: N<=Len, with Len==0 or Len>DEPTH replaced by DEPTH; go to LOAD.
//   Write and Start in the same cycle: the write lands first, so the scan sees the new data.
//  LOAD: Max<=M[0], Min<=M[0], Max_Idx<=0, Min_Idx<=0, I<=1.
//   Go to DONE if N==1, else to CMP.
//  CMP: compare M[I] against current Max and Min in the same cycle.
//   If M[I]>Max (strict): Max<=M[I], Max_Idx<=I.
//   If M[I]<Min (strict): Min<=M[I], Min_Idx<=I.
//   Ties keep the lowest index. Compares use SIGNED mode.
//   If I==N-1 go to DONE, else I<=I+1. I never wraps.
//  DONE: Done=1; Max, Min and indices are held stable. Stay until Ack, then go to INI.
//   Start in DONE is ignored. Ack outside DONE is ignored.
//  Latency: Start seen at edge t -> LOAD at t+1 -> Done first high after edge t+N+1 (N=1: t+2).
//  Wr_En outside INI is ignored; the array is immutable during a scan.
//  Outputs are registered and update only on state actions above. There is no combinational path from inputs.
// TESTING
//  1. Unsigned; M=0..15 ascending; Len=16; Start -> Done at edge t+17; Max=15, Idx=15; Min=0, Idx=0.
//  2. SIGNED=1; M[0..3]={8'h7F,8'h80,8'hFF,8'h01}; Len=4 -> Max=8'h7F, Idx=0; Min=8'h80, Idx=1.
//  3. Ties: M all 8'h2A; Len=16 -> Max=Min=8'h2A, both Idx=0. Len=1 -> Done at t+2.
//  4. Len=0 and Len=20 -> both scan 16 entries. Len=5 with max at index 9 -> index 9 excluded.
//  5. Hold Ack low 10 cycles -> Done and results stable. Ack -> INI. Start while in DONE -> no effect.
//  6. Reset_n low during CMP -> immediately INI, outputs 0, array intact.
//     Wr_En during CMP -> M unchanged. Wr_En+Start same cycle -> new value used.

Source files
------------

// File: rtl/min_max_finder_param_if.sv
// Bus bundle for min_max_finder_param: array write port, scan request/acknowledge
// and the registered scan results.
interface min_max_finder_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: Start (with Len) is accepted only while the finder is idle; Done stays
  // high with Max/Min/indices stable until Ack is seen while Done is high, which
  // returns the finder to idle. Start outside idle and Ack outside Done are ignored.
  logic             Wr_En;
  logic [AW-1:0]    Wr_Addr;
  logic [WIDTH-1:0] Wr_Data;
  logic             Start;
  logic [AW:0]      Len;
  logic             Ack;
  logic [WIDTH-1:0] Max;
  logic [WIDTH-1:0] Min;
  logic [AW-1:0]    Max_Idx;
  logic [AW-1:0]    Min_Idx;
  logic             Done;

  modport master (
    output Wr_En, Wr_Addr, Wr_Data, Start, Len, Ack,
    input  Max, Min, Max_Idx, Min_Idx, Done
  );

  modport slave (
    input  Wr_En, Wr_Addr, Wr_Data, Start, Len, Ack,
    output Max, Min, Max_Idx, Min_Idx, Done
  );
endinterface

// File: rtl/min_max_finder_param.sv
// Scans the first Len entries of an internal DEPTH x WIDTH array and reports the
// largest/smallest element with their lowest indices; one-hot state is exported.
module min_max_finder_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter bit SIGNED = 1'b0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic Clk,
  input  logic Reset_n,
  min_max_finder_param_if.slave bus,
  output logic Qi,
  output logic Ql,
  output logic Qc,
  output logic Qd
);

  typedef enum logic [3:0] {
    INI  = 4'b0001,
    LOAD = 4'b0010,
    CMP  = 4'b0100,
    DONE = 4'b1000
  } state_t;

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW:0]      n;
  logic [WIDTH-1:0] max_r, min_r;
  logic [AW-1:0]    max_idx_r, min_idx_r;
  logic [WIDTH-1:0] cur;
  logic             last;

  assign cur  = mem[idx];
  assign last = ({1'b0, idx} == n - 1'b1);

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= INI;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      INI:     if (bus.Start) state_next = LOAD;
      LOAD:    state_next = (n == (AW+1)'(1)) ? DONE : CMP;
      CMP:     if (last) state_next = DONE;
      DONE:    if (bus.Ack) state_next = INI;
      default: state_next = INI;
    endcase
  end

  // Array contents survive reset; writes only land while idle.
  always_ff @(posedge Clk) begin
    if (state == INI && bus.Wr_En && ({1'b0, bus.Wr_Addr} < DEPTH_N))
      mem[bus.Wr_Addr] <= bus.Wr_Data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      max_r     <= '0;
      min_r     <= '0;
      max_idx_r <= '0;
      min_idx_r <= '0;
      idx       <= '0;
      n         <= '0;
    end else begin
      unique case (state)
        INI: begin
          idx <= '0;
          if (bus.Start)
            n <= (bus.Len == '0 || bus.Len > DEPTH_N) ? DEPTH_N : bus.Len;
        end
        LOAD: begin
          max_r     <= mem[0];
          min_r     <= mem[0];
          max_idx_r <= '0;
          min_idx_r <= '0;
          idx       <= (AW)'(1);
        end
        CMP: begin
          // Strict compares so ties keep the earlier index.
          if (greater(cur, max_r)) begin
            max_r     <= cur;
            max_idx_r <= idx;
          end
          if (greater(min_r, cur)) begin
            min_r     <= cur;
            min_idx_r <= idx;
          end
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Max     = max_r;
  assign bus.Min     = min_r;
  assign bus.Max_Idx = max_idx_r;
  assign bus.Min_Idx = min_idx_r;
  assign bus.Done    = (state == DONE);

  assign Qi = state[0];
  assign Ql = state[1];
  assign Qc = state[2];
  assign Qd = state[3];

endmodule
